autotype_sequencer: RTL and testbench

Parametrised power-on keystroke player that drives a retro-computer core's reset and button inputs from a script, so boards with no buttons or keyboard boot straight into a usable state. It generalises the fixed reset/B/C/ENTER demo sequence: the key count, script, step timing and press length are parameters. It adds start, abort and repeat behaviour, plus busy/done status. It sits in the top level between the clock/PLL and the machine core, on the pixel clock.

---
 rtl/autotype_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_autotype_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/autotype_sequencer.sv
// Scripted power-on keystroke player: drives a core's reset and one-hot key inputs from a step table.
// All outputs registered; start/abort act one edge after they are sampled, step entry updates outputs on the entry edge.
module autotype_sequencer #(
    parameter int                     NUM_KEYS    = 4,
    parameter int                     NUM_STEPS   = 8,
    parameter logic [NUM_STEPS*8-1:0] SCRIPT      = '0,
    parameter int                     STEP_CYCLES = 2**23,
    parameter int                     HOLD_CYCLES = 2**21,
    parameter bit                     AUTO_START  = 1'b1,
    parameter bit                     REPEAT      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic                n_reset_out,
    output logic                busy,
    output logic                done,
    output logic [5:0]          step_idx
);

    localparam int             CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_REL   = CW'(HOLD_CYCLES - 1);
    localparam logic [5:0]     STEP_LAST = 6'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                boot;
    logic [NUM_KEYS-1:0] keys_nxt;
    logic                nrst_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [5:0]          step_nxt;
    logic                enter;
    logic [5:0]          enter_step;
    logic [7:0]          entry_byte;

    function automatic logic [7:0] script_byte(input logic [5:0] s);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (s == 6'(i)) b = SCRIPT[8*i +: 8];
        end
        return b;
    endfunction

    function automatic logic step_is_end(input logic [5:0] s);
        logic e;
        e = 1'b0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (s == 6'(i)) e = SCRIPT[8*i + 7];
        end
        return e;
    endfunction

    // Indices at or beyond NUM_KEYS (including 63) decode to no key: a delay step.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [5:0] idx);
        logic [NUM_KEYS-1:0] k;
        k = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (idx == 6'(i)) k[i] = 1'b1;
        end
        return k;
    endfunction

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        keys_nxt   = keys_out;
        nrst_nxt   = n_reset_out;
        busy_nxt   = busy;
        done_nxt   = done;
        step_nxt   = step_idx;
        enter      = 1'b0;
        enter_step = '0;

        case (state)
            IDLE: begin
                keys_nxt = '0;
                nrst_nxt = 1'b1;
                if (start || (boot && AUTO_START)) enter = 1'b1;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    keys_nxt  = '0;
                    nrst_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else if (start) begin
                    enter = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    // An END step only stays in RUN when wrapping, so it always leads back to step 0.
                    if (step_idx == STEP_LAST || step_is_end(step_idx)) begin
                        if (REPEAT) begin
                            enter = 1'b1;
                        end else begin
                            state_nxt = DONE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                            keys_nxt  = '0;
                            nrst_nxt  = 1'b1;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        enter      = 1'b1;
                        enter_step = step_idx + 6'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CNT_REL) begin
                        keys_nxt = '0;
                        nrst_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) enter = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        entry_byte = script_byte(enter_step);
        if (enter) begin
            step_nxt = enter_step;
            keys_nxt = '0;
            nrst_nxt = 1'b1;
            cnt_nxt  = '0;
            if (entry_byte[7]) begin
                if (REPEAT) begin
                    // Park on the last count so the very next edge wraps to step 0.
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    cnt_nxt   = CNT_LAST;
                end else begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end else begin
                state_nxt = RUN;
                busy_nxt  = 1'b1;
                done_nxt  = 1'b0;
                if (entry_byte[6]) nrst_nxt = 1'b0;
                else               keys_nxt = key_onehot(entry_byte[5:0]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            boot        <= 1'b1;
            keys_out    <= '0;
            n_reset_out <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_idx    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            boot        <= 1'b0;
            keys_out    <= keys_nxt;
            n_reset_out <= nrst_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            step_idx    <= step_nxt;
        end
    end

endmodule

// File: tb/tb_autotype_sequencer.sv
// Directed bench for autotype_sequencer: base script, END-terminated script and REPEAT variant side by side.
module tb_autotype_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;

    logic [3:0] b_keys, e_keys, r_keys;
    logic       b_nrst, e_nrst, r_nrst;
    logic       b_busy, e_busy, r_busy;
    logic       b_done, e_done, r_done;
    logic [5:0] b_idx, e_idx, r_idx;

    int total = 0;
    int bad   = 0;

    autotype_sequencer #(
        .NUM_KEYS(4), .NUM_STEPS(4), .SCRIPT(32'h023F_0140),
        .STEP_CYCLES(8), .HOLD_CYCLES(3), .AUTO_START(1'b1), .REPEAT(1'b0)
    ) u_base (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .keys_out(b_keys), .n_reset_out(b_nrst), .busy(b_busy), .done(b_done), .step_idx(b_idx)
    );

    autotype_sequencer #(
        .NUM_KEYS(4), .NUM_STEPS(4), .SCRIPT(32'h0280_0140),
        .STEP_CYCLES(8), .HOLD_CYCLES(3), .AUTO_START(1'b1), .REPEAT(1'b0)
    ) u_end (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .keys_out(e_keys), .n_reset_out(e_nrst), .busy(e_busy), .done(e_done), .step_idx(e_idx)
    );

    autotype_sequencer #(
        .NUM_KEYS(4), .NUM_STEPS(4), .SCRIPT(32'h023F_0140),
        .STEP_CYCLES(8), .HOLD_CYCLES(3), .AUTO_START(1'b1), .REPEAT(1'b1)
    ) u_rep (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .keys_out(r_keys), .n_reset_out(r_nrst), .busy(r_busy), .done(r_done), .step_idx(r_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected base-script waveform; cycle c is the state after the c-th edge following reset release.
    function automatic logic [3:0] exp_keys(input int c);
        if (c >= 9 && c <= 11)  return 4'b0010;
        if (c >= 25 && c <= 27) return 4'b0100;
        return 4'b0000;
    endfunction

    function automatic logic exp_nrst(input int c);
        return (c <= 3) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        return (c >= 1 && c <= 32) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [5:0] exp_idx(input int c);
        if (c <= 8)  return 6'd0;
        if (c <= 16) return 6'd1;
        if (c <= 24) return 6'd2;
        return 6'd3;
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_base(input int c);
        chk("base.keys", c, 64'(b_keys), 64'(exp_keys(c)));
        chk("base.nrst", c, 64'(b_nrst), 64'(exp_nrst(c)));
        chk("base.busy", c, 64'(b_busy), 64'(exp_busy(c)));
        chk("base.done", c, 64'(b_done), 64'(c >= 33));
        if (c <= 32) chk("base.idx", c, 64'(b_idx), 64'(exp_idx(c)));
    endtask

    task automatic check_end(input int c);
        chk("end.keys", c, 64'(e_keys), 64'((c >= 9 && c <= 11) ? 4'b0010 : 4'b0000));
        chk("end.nrst", c, 64'(e_nrst), 64'(exp_nrst(c)));
        chk("end.busy", c, 64'(e_busy), 64'(c >= 1 && c <= 16));
        chk("end.done", c, 64'(e_done), 64'(c >= 17));
        if (c <= 16) chk("end.idx", c, 64'(e_idx), 64'(exp_idx(c)));
    endtask

    task automatic check_rep(input int c);
        int p;
        p = (c == 0) ? 0 : ((c - 1) % 32) + 1;
        chk("rep.keys", c, 64'(r_keys), 64'(exp_keys(p)));
        chk("rep.nrst", c, 64'(r_nrst), 64'(exp_nrst(p)));
        chk("rep.busy", c, 64'(r_busy), 64'(c >= 1));
        chk("rep.done", c, 64'(r_done), 64'(0));
        chk("rep.idx",  c, 64'(r_idx),  64'(exp_idx(p)));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".keys"}, 0, 64'(b_keys), 64'(0));
        chk({tag, ".nrst"}, 0, 64'(b_nrst), 64'(0));
        chk({tag, ".busy"}, 0, 64'(b_busy), 64'(0));
        chk({tag, ".done"}, 0, 64'(b_done), 64'(0));
        chk({tag, ".idx"},  0, 64'(b_idx),  64'(0));
        chk({tag, ".rep_nrst"}, 0, 64'(r_nrst), 64'(0));
        chk({tag, ".rep_busy"}, 0, 64'(r_busy), 64'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        // Reset asserted before any clock edge: clear must be asynchronous.
        #2 reset = 1'b1;
        #1 check_reset_vals("por");

        // Full script on all three variants from the release edge.
        do_reset();
        check_base(0);
        check_end(0);
        check_rep(0);
        for (int c = 1; c <= 70; c++) begin
            tick();
            check_base(c);
            check_end(c);
            check_rep(c);
        end

        // Restart from DONE; the start edge is replay cycle 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.done", 1, 64'(b_done), 64'(0));
        chk("start.busy", 1, 64'(b_busy), 64'(1));
        chk("start.idx",  1, 64'(b_idx),  64'(0));
        chk("start.nrst", 1, 64'(b_nrst), 64'(0));
        chk("start.keys", 1, 64'(b_keys), 64'(0));
        for (int r = 2; r <= 40; r++) begin
            tick();
            check_base(r);
        end

        // Abort during the key-1 hold.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            check_base(c);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.keys", 11, 64'(b_keys), 64'(0));
        chk("abort.busy", 11, 64'(b_busy), 64'(0));
        chk("abort.done", 11, 64'(b_done), 64'(0));
        chk("abort.nrst", 11, 64'(b_nrst), 64'(1));
        for (int c = 12; c <= 40; c++) begin
            tick();
            chk("quiet.keys", c, 64'(b_keys), 64'(0));
            chk("quiet.nrst", c, 64'(b_nrst), 64'(1));
            chk("quiet.busy", c, 64'(b_busy), 64'(0));
            chk("quiet.done", c, 64'(b_done), 64'(0));
        end

        // Reset pulsed mid-step at cycle 20, then a clean replay.
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            tick();
            check_base(c);
        end
        #3 reset = 1'b1;
        #1 check_reset_vals("midrst");
        tick();
        reset = 1'b0;
        check_base(0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            check_base(c);
        end

        // abort is ignored in DONE, start still restarts, then abort beats start in RUN.
        abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("doneabort.done", k, 64'(b_done), 64'(1));
            chk("doneabort.busy", k, 64'(b_busy), 64'(0));
        end
        start = 1'b1;
        tick();
        chk("donestart.busy", 0, 64'(b_busy), 64'(1));
        chk("donestart.done", 0, 64'(b_done), 64'(0));
        chk("donestart.nrst", 0, 64'(b_nrst), 64'(0));
        tick();
        chk("prio.busy", 0, 64'(b_busy), 64'(0));
        chk("prio.nrst", 0, 64'(b_nrst), 64'(1));
        chk("prio.keys", 0, 64'(b_keys), 64'(0));
        chk("prio.done", 0, 64'(b_done), 64'(0));
        start = 1'b0;
        abort = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
